bus_timer: RTL and testbench
============================

BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  system fast clock; sole clock, all state changes on its rising edge.
REQ-003 res  in  1  reset; synchronous, active-high.
REQ-004 phi2  in  1  CPU bus phase-2 level, synchronous to clk and slower than clk.
REQ-005 cs  in  1  chip select, active-high.
REQ-006 rw  in  1  CPU direction: 1 = read, 0 = write.
REQ-007 rs  in  2  register select.
REQ-008 dbi  in  8  write data from CPU.
REQ-009 dbo  out  8  read data to CPU.
REQ-010 irq_n  out  1  interrupt request, active-low.

Function
REQ-011 phi2_q SHALL register phi2 each clk; tick = phi2_q & ~phi2, asserted for exactly one clk per CPU cycle.
REQ-012 Bus accesses SHALL take effect only on tick with cs=1; cs, rw, rs and dbi SHALL be sampled on that clk.
REQ-013 State: latch[15:0], counter[15:0], ctrl[1:0] (bit0 FR = free-run, bit1 IE), IF flag and RUN flag.
REQ-014 Write rs=0 SHALL load latch[7:0] from dbi with no other effect.
REQ-015 Write rs=1 SHALL do all of the following:
- load latch[15:8] from dbi;
- load counter with {dbi, latch[7:0]};
- clear IF;
- set RUN.
REQ-016 Write rs=2 SHALL load ctrl from dbi[1:0].
REQ-017 Write rs=3 SHALL clear IF, whatever the value of dbi.
REQ-018 dbo SHALL be combinational: cs=1 & rw=1 selects by rs, otherwise 8'h00.
- rs=0: counter[7:0]
- rs=1: counter[15:8]
- rs=2: {6'b0, ctrl}
- rs=3: {IF, 6'b0, RUN}
REQ-019 Read side effect: a read of rs=0 on tick SHALL clear IF; reads of other registers SHALL have no side effect.
REQ-020 Counting SHALL happen only on tick with RUN=1 and SHALL depend on counter.
- counter != 0: decrement by 1.
- counter == 0: set IF, and in free-run (FR=1) reload counter from latch with RUN kept at 1.
- counter == 0 in one-shot (FR=0): clear RUN and hold counter at 0.
REQ-021 The counter SHALL never wrap from 0 to FFFF.
REQ-022 Expiry period SHALL be latch+1 ticks; latch=0 with FR=1 SHALL set IF on every tick.
REQ-023 irq_n SHALL equal ~(IF & IE), combinationally from registered state.
REQ-024 Simultaneous events on the same tick, in priority order:
- write rs=1 beats counting: counter is loaded and IF cleared, any expiry is discarded;
- expiry set of IF beats a clearing read or write (rs=0 read, rs=3 write), so IF stays 1;
- write rs=2 takes effect for the next tick only, not the current one.
REQ-025 With phi2 held constant, no tick SHALL occur, so state holds and bus writes are ignored.
REQ-026 Implementation SHALL be 120-400 lines of RTL.

Reset
REQ-027 While res=1 on a clk edge, state SHALL take these values, with res overriding any concurrent tick or access:
- latch = 16'hFFFF, counter = 16'hFFFF;
- ctrl = 0, IF = 0, RUN = 0;
- phi2_q = 0.
REQ-028 Out of reset, irq_n SHALL be 1 and dbo SHALL be 8'h00 (cs=0).
REQ-029 Reset asserted mid-count SHALL abort the count: RUN = 0, and no IF is set afterwards until a new rs=1 write.

Verification
REQ-030 One-shot: reset; write rs=2 = 02, rs=0 = 03, rs=1 = 00. Required: counter reads 3,2,1,0 on successive ticks; IF=1 and irq_n=0 on the 4th tick after the load; RUN=0; counter stays 0.
REQ-031 Free-run: ctrl = 03, latch = 0002. Required: IF set every 3 ticks; counter sequence 2,1,0,2,1,0.
REQ-032 IF clear: after expiry, a read of rs=0 returns counter[7:0], then IF=0 and irq_n=1; a separate write of rs=3 = 5A also clears IF.
REQ-033 Collisions:
- expiry tick coinciding with an rs=0 read: IF=1;
- expiry tick coinciding with an rs=1 write of 10 (latch low = 00): counter = 1000, IF=0.
REQ-034 Reset at counter=5 with RUN=1: all REQ-027 values; no IF after 10 further ticks.
REQ-035 Bus gating: with IE=0 and IF=1, irq_n=1; with cs=0, dbo=00 and writes to any rs are ignored.

Source files
------------

// File: rtl/bus_timer.sv
// ============================================================================
// Module   : bus_timer
// Brief    : 16-bit CPU-bus programmable down-counter timer with interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timer (
    input  logic       clk,
    input  logic       res,
    input  logic       phi2,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] rs,
    input  logic [7:0] dbi,
    output logic [7:0] dbo,
    output logic       irq_n
);

    localparam logic [1:0] c_RS_LO   = 2'd0;
    localparam logic [1:0] c_RS_HI   = 2'd1;
    localparam logic [1:0] c_RS_CTRL = 2'd2;
    localparam logic [1:0] c_RS_STAT = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic        r_phi2_q;
    logic [15:0] r_latch;
    logic [15:0] r_counter;
    logic [1:0]  r_ctrl;
    logic        r_if;
    state_t      r_state;

    logic w_tick;
    logic w_wr;
    logic w_rd;
    logic w_wr_lo;
    logic w_wr_hi;
    logic w_wr_ctrl;
    logic w_wr_stat;
    logic w_rd_lo;
    logic w_run;
    logic w_fr;
    logic w_ie;
    logic w_cnt_zero;
    logic w_expire;
    logic w_if_clr;

    // One tick per CPU cycle: the clk edge on which phi2 is seen falling.
    assign w_tick     = r_phi2_q & ~phi2;
    assign w_wr       = w_tick & cs & ~rw;
    assign w_rd       = w_tick & cs &  rw;
    assign w_wr_lo    = w_wr & (rs == c_RS_LO);
    assign w_wr_hi    = w_wr & (rs == c_RS_HI);
    assign w_wr_ctrl  = w_wr & (rs == c_RS_CTRL);
    assign w_wr_stat  = w_wr & (rs == c_RS_STAT);
    assign w_rd_lo    = w_rd & (rs == c_RS_LO);

    assign w_run      = (r_state == ST_RUN);
    assign w_fr       = r_ctrl[0];
    assign w_ie       = r_ctrl[1];
    assign w_cnt_zero = (r_counter == 16'h0000);

    // A high-byte write restarts the count, so it suppresses a coincident expiry.
    assign w_expire   = w_tick & w_run & w_cnt_zero & ~w_wr_hi;
    assign w_if_clr   = w_wr_hi | w_wr_stat | w_rd_lo;

    always_ff @(posedge clk) begin
        if (res) begin
            r_phi2_q <= 1'b0;
        end else begin
            r_phi2_q <= phi2;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_latch <= 16'hFFFF;
        end else begin
            if (w_wr_lo) begin
                r_latch[7:0] <= dbi;
            end
            if (w_wr_hi) begin
                r_latch[15:8] <= dbi;
            end
        end
    end

    // Control changes land at the tick edge, so the counting below still sees the old mode.
    always_ff @(posedge clk) begin
        if (res) begin
            r_ctrl <= 2'b00;
        end else if (w_wr_ctrl) begin
            r_ctrl <= dbi[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_counter <= 16'hFFFF;
            r_state   <= ST_IDLE;
        end else if (w_wr_hi) begin
            r_counter <= {dbi, r_latch[7:0]};
            r_state   <= ST_RUN;
        end else if (w_tick && w_run) begin
            if (!w_cnt_zero) begin
                r_counter <= r_counter - 16'd1;
            end else if (w_fr) begin
                r_counter <= r_latch;
            end else begin
                r_state   <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_if <= 1'b0;
        end else if (w_expire) begin
            r_if <= 1'b1;
        end else if (w_if_clr) begin
            r_if <= 1'b0;
        end
    end

    always_comb begin
        dbo = 8'h00;
        if (cs && rw) begin
            case (rs)
                c_RS_LO:   dbo = r_counter[7:0];
                c_RS_HI:   dbo = r_counter[15:8];
                c_RS_CTRL: dbo = {6'b000000, r_ctrl};
                default:   dbo = {r_if, 6'b000000, w_run};
            endcase
        end
    end

    assign irq_n = ~(r_if & w_ie);

endmodule

`default_nettype wire

// File: tb/tb_bus_timer.sv
// ============================================================================
// Module   : tb_bus_timer
// Brief    : Directed self-checking bench for bus_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_timer;

    logic       clk;
    logic       res;
    logic       phi2;
    logic       cs;
    logic       rw;
    logic [1:0] rs;
    logic [7:0] dbi;
    logic [7:0] dbo;
    logic       irq_n;

    int n_checks;
    int n_errors;
    logic [7:0] r_q;

    bus_timer u_dut (
        .clk   (clk),
        .res   (res),
        .phi2  (phi2),
        .cs    (cs),
        .rw    (rw),
        .rs    (rs),
        .dbi   (dbi),
        .dbo   (dbo),
        .irq_n (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU cycle: phi2 high for one clk, then low; exactly one tick results.
    // Returns dbo as seen during the access, before the tick edge.
    task automatic cyc(input logic c, input logic r, input logic [1:0] a,
                       input logic [7:0] d, output logic [7:0] q);
        @(negedge clk);
        cs = c; rw = r; rs = a; dbi = d; phi2 = 1'b1;
        @(negedge clk);
        phi2 = 1'b0;
        #1 q = dbo;
        @(negedge clk);
        cs = 1'b0; rw = 1'b0; rs = 2'd0; dbi = 8'h00;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] q;
        cyc(1'b1, 1'b0, a, d, q);
    endtask

    task automatic idle(input int n);
        logic [7:0] q;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, q);
    endtask

    // Combinational read with phi2 steady: no tick, hence no side effect.
    task automatic peek(input logic [1:0] a, output logic [7:0] q);
        cs = 1'b1; rw = 1'b1; rs = a;
        #1 q = dbo;
        cs = 1'b0; rw = 1'b0; rs = 2'd0;
    endtask

    task automatic peek_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] q;
        peek(a, q);
        check(tag, {8'h00, q}, {8'h00, exp});
    endtask

    task automatic do_reset();
        res = 1'b1; phi2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        res = 1'b1; phi2 = 1'b0; cs = 1'b0; rw = 1'b0; rs = 2'd0; dbi = 8'h00;
        do_reset();

        // Reset state
        #1;
        check("rst_irq_n", {15'd0, irq_n}, 16'd1);
        check("rst_dbo_cs0", {8'h00, dbo}, 16'h0000);
        peek_chk("rst_cnt_lo", 2'd0, 8'hFF);
        peek_chk("rst_cnt_hi", 2'd1, 8'hFF);
        peek_chk("rst_ctrl", 2'd2, 8'h00);
        peek_chk("rst_stat", 2'd3, 8'h00);

        // One-shot, latch = 3
        wr(2'd2, 8'h02); wr(2'd0, 8'h03); wr(2'd1, 8'h00);
        peek_chk("os_cnt3", 2'd0, 8'h03);
        peek_chk("os_cnt_hi", 2'd1, 8'h00);
        idle(1); peek_chk("os_cnt2", 2'd0, 8'h02);
        idle(1); peek_chk("os_cnt1", 2'd0, 8'h01);
        idle(1); peek_chk("os_cnt0", 2'd0, 8'h00);
        peek_chk("os_stat_run", 2'd3, 8'h01);
        check("os_irq_pre", {15'd0, irq_n}, 16'd1);
        idle(1);
        peek_chk("os_stat_exp", 2'd3, 8'h80);
        check("os_irq_exp", {15'd0, irq_n}, 16'd0);
        idle(2);
        peek_chk("os_cnt_hold", 2'd0, 8'h00);
        peek_chk("os_cnt_hold_hi", 2'd1, 8'h00);

        // IF clear via rs=0 read, then via rs=3 write
        cyc(1'b1, 1'b1, 2'd0, 8'h00, r_q);
        check("clr_rd_data", {8'h00, r_q}, 16'h0000);
        peek_chk("clr_rd_stat", 2'd3, 8'h00);
        check("clr_rd_irq", {15'd0, irq_n}, 16'd1);
        wr(2'd1, 8'h00);
        idle(4);
        peek_chk("clr_wr_pre", 2'd3, 8'h80);
        wr(2'd3, 8'h5A);
        peek_chk("clr_wr_stat", 2'd3, 8'h00);
        check("clr_wr_irq", {15'd0, irq_n}, 16'd1);

        // Free-run, latch = 0002
        wr(2'd2, 8'h03); wr(2'd0, 8'h02); wr(2'd1, 8'h00);
        peek_chk("fr_c2", 2'd0, 8'h02);
        idle(1); peek_chk("fr_c1", 2'd0, 8'h01);
        idle(1); peek_chk("fr_c0", 2'd0, 8'h00);
        peek_chk("fr_stat_pre", 2'd3, 8'h01);
        idle(1); peek_chk("fr_reload", 2'd0, 8'h02);
        peek_chk("fr_stat_exp1", 2'd3, 8'h81);
        check("fr_irq", {15'd0, irq_n}, 16'd0);
        wr(2'd3, 8'h00);
        peek_chk("fr_c1b", 2'd0, 8'h01);
        peek_chk("fr_stat_clr", 2'd3, 8'h01);
        idle(1); peek_chk("fr_c0b", 2'd0, 8'h00);
        peek_chk("fr_stat_noexp", 2'd3, 8'h01);
        idle(1); peek_chk("fr_reload2", 2'd0, 8'h02);
        peek_chk("fr_stat_exp2", 2'd3, 8'h81);

        // Collision: expiry with rs=0 read keeps IF set
        wr(2'd3, 8'h00);
        idle(1);
        peek_chk("col_rd_pre", 2'd3, 8'h01);
        cyc(1'b1, 1'b1, 2'd0, 8'h00, r_q);
        check("col_rd_data", {8'h00, r_q}, 16'h0000);
        peek_chk("col_rd_stat", 2'd3, 8'h81);

        // Collision: expiry with rs=1 write of 10 (latch low 00)
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h00);
        peek_chk("col_wr_pre_cnt", 2'd0, 8'h00);
        wr(2'd1, 8'h10);
        peek_chk("col_wr_hi", 2'd1, 8'h10);
        peek_chk("col_wr_lo", 2'd0, 8'h00);
        peek_chk("col_wr_stat", 2'd3, 8'h01);

        // latch = 0 free-run with IE = 0: IF every tick, irq masked
        wr(2'd2, 8'h01);
        wr(2'd1, 8'h00);
        idle(1);
        peek_chk("l0_stat", 2'd3, 8'h81);
        check("ie0_irq_n", {15'd0, irq_n}, 16'd1);
        wr(2'd3, 8'h00);
        peek_chk("l0_stat_clr_lost", 2'd3, 8'h81);

        // Bus gating: cs=0 reads zero and ignores writes; no tick without phi2 edge
        cs = 1'b0; rw = 1'b1; rs = 2'd3;
        #1 check("cs0_dbo", {8'h00, dbo}, 16'h0000);
        rw = 1'b0;
        cyc(1'b0, 1'b0, 2'd2, 8'h02, r_q);
        cyc(1'b0, 1'b0, 2'd1, 8'h55, r_q);
        peek_chk("cs0_ctrl", 2'd2, 8'h01);
        peek_chk("cs0_cnt_hi", 2'd1, 8'h00);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; rs = 2'd2; dbi = 8'h03;
        repeat (5) @(negedge clk);
        cs = 1'b0;
        peek_chk("nophi_ctrl", 2'd2, 8'h01);

        // Reset mid-count aborts the count
        wr(2'd2, 8'h02); wr(2'd0, 8'h08); wr(2'd1, 8'h00);
        idle(3);
        peek_chk("mid_cnt5", 2'd0, 8'h05);
        peek_chk("mid_stat", 2'd3, 8'h01);
        do_reset();
        #1;
        peek_chk("mid_rst_lo", 2'd0, 8'hFF);
        peek_chk("mid_rst_hi", 2'd1, 8'hFF);
        peek_chk("mid_rst_ctrl", 2'd2, 8'h00);
        peek_chk("mid_rst_stat", 2'd3, 8'h00);
        check("mid_rst_irq", {15'd0, irq_n}, 16'd1);
        idle(10);
        peek_chk("mid_after_stat", 2'd3, 8'h00);
        peek_chk("mid_after_lo", 2'd0, 8'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
